// File: rtl/dsram_resp.sv
// Data-side SRAM with fixed-latency, in-order responses and a bounded outstanding queue.
// Loads read the word before any same-edge store; illegal accesses answer err=1 and write nothing.
module dsram_resp #(
    parameter int unsigned AW       = 10,
    parameter int unsigned LAT      = 2,
    parameter int unsigned OQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned PW      = (OQ_DEPTH > 1) ? $clog2(OQ_DEPTH) : 1;
    localparam int unsigned Words   = 1 << AW;
    localparam logic [2:0]  CntInit = 3'(LAT - 1);
    localparam logic [2:0]  Depth   = 3'(OQ_DEPTH);
    localparam logic [PW-1:0] PtrLast = PW'(OQ_DEPTH - 1);

    logic [31:0]   mem [Words];
    logic [AW-1:0] widx;
    logic          illegal;
    logic [3:0]    be;
    logic          accept;
    logic          retire;
    logic          new_err;
    logic [31:0]   new_data;

    logic          ent_err_q  [OQ_DEPTH];
    logic          ent_err_d  [OQ_DEPTH];
    logic [31:0]   ent_data_q [OQ_DEPTH];
    logic [31:0]   ent_data_d [OQ_DEPTH];
    logic [2:0]    ent_cnt_q  [OQ_DEPTH];
    logic [2:0]    ent_cnt_d  [OQ_DEPTH];
    logic [2:0]    count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_data_q, rsp_data_d;

    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    assign widx    = addr[AW+1:2];
    assign addr_ok = reset && (count_q < Depth);
    assign accept  = req && addr_ok;
    assign data_ok = rsp_vld_q;
    assign err     = rsp_err_q;
    assign rdata   = rsp_data_q;

    always_comb begin
        be      = 4'b0000;
        illegal = 1'b0;
        unique case (size)
            2'd0: be = 4'b0001 << addr[1:0];
            2'd1: begin
                illegal = addr[0];
                be      = addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                illegal = (addr[1:0] != 2'b00);
                be      = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign new_err  = illegal;
    assign new_data = (!illegal && !wr) ? mem[widx] : 32'h0;

    always_ff @(posedge clk) begin
        if (accept && wr && !illegal) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // The head moves into the response register on the edge its countdown reaches
    // zero, so it leaves the count one cycle before data_ok and keeps full throughput.
    assign retire = (count_q != 3'd0) && (ent_cnt_q[rd_ptr_q] == 3'd1);

    always_comb begin
        for (int i = 0; i < OQ_DEPTH; i++) begin
            ent_err_d[i]  = ent_err_q[i];
            ent_data_d[i] = ent_data_q[i];
            ent_cnt_d[i]  = (ent_cnt_q[i] != 3'd0) ? ent_cnt_q[i] - 3'd1 : 3'd0;
        end
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rsp_vld_d  = 1'b0;
        rsp_err_d  = 1'b0;
        rsp_data_d = 32'h0;

        if (retire) begin
            rsp_vld_d  = 1'b1;
            rsp_err_d  = ent_err_q[rd_ptr_q];
            rsp_data_d = ent_data_q[rd_ptr_q];
            rd_ptr_d   = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end

        if (accept) begin
            if (LAT == 1) begin
                // Single-cycle latency bypasses the queue entirely.
                rsp_vld_d  = 1'b1;
                rsp_err_d  = new_err;
                rsp_data_d = new_data;
            end else begin
                ent_err_d[wr_ptr_q]  = new_err;
                ent_data_d[wr_ptr_q] = new_data;
                ent_cnt_d[wr_ptr_q]  = CntInit;
                wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
        end

        if (accept && (LAT > 1) && !retire) begin
            count_d = count_q + 3'd1;
        end else if (!(accept && (LAT > 1)) && retire) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < OQ_DEPTH; i++) begin
                ent_err_q[i]  <= 1'b0;
                ent_data_q[i] <= 32'h0;
                ent_cnt_q[i]  <= 3'd0;
            end
            count_q    <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= 32'h0;
        end else begin
            for (int i = 0; i < OQ_DEPTH; i++) begin
                ent_err_q[i]  <= ent_err_d[i];
                ent_data_q[i] <= ent_data_d[i];
                ent_cnt_q[i]  <= ent_cnt_d[i];
            end
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_dsram_resp.sv
// Directed bench for dsram_resp: two instances share stimulus, one at LAT=2 and one at LAT=3,
// both with OQ_DEPTH=2.
module tb_dsram_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        a_addr_ok, a_data_ok, a_err;
    logic [31:0] a_rdata;
    logic        b_addr_ok, b_data_ok, b_err;
    logic [31:0] b_rdata;

    always #5 clk = ~clk;

    dsram_resp #(.AW(10), .LAT(2), .OQ_DEPTH(2)) u_dut_a (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata), .err(a_err)
    );

    dsram_resp #(.AW(10), .LAT(3), .OQ_DEPTH(2)) u_dut_b (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata), .err(b_err)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] exp;
    } op_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   a_acc[$];
    int   b_acc[$];
    rsp_t a_rsp[$];
    rsp_t b_rsp[$];
    op_t  ops[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (req && a_addr_ok) a_acc.push_back(cyc);
            if (req && b_addr_ok) b_acc.push_back(cyc);
            if (a_data_ok) a_rsp.push_back('{cyc, a_err, a_rdata});
            if (b_data_ok) b_rsp.push_back('{cyc, b_err, b_rdata});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        a_acc.delete(); b_acc.delete(); a_rsp.delete(); b_rsp.delete();
    endtask

    task automatic add_op(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic e, input logic [31:0] x);
        ops.push_back('{w, s, a, d, e, x});
    endtask

    // Presents each op in turn, holding req until the selected instance accepts it.
    task automatic issue_all(input bit use_b);
        foreach (ops[k]) begin
            int guard = 0;
            req = 1'b1; wr = ops[k].wr; size = ops[k].size;
            addr = ops[k].addr; wdata = ops[k].wdata;
            forever begin
                @(negedge clk);
                if (use_b ? b_addr_ok : a_addr_ok) break;
                guard++;
                if (guard > 20) begin
                    check_eq("issue_timeout", 32'(guard), 32'd0);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rsps(input string tag, input bit use_b, input int lat);
        rsp_t rs[$];
        int   ac[$];
        if (use_b) begin rs = b_rsp; ac = b_acc; end
        else begin rs = a_rsp; ac = a_acc; end
        check_eq({tag, "_nacc"}, 32'(ac.size()), 32'(ops.size()));
        check_eq({tag, "_nrsp"}, 32'(rs.size()), 32'(ops.size()));
        foreach (ops[i]) begin
            if (i < rs.size() && i < ac.size()) begin
                check_eq($sformatf("%s_err%0d", tag, i), 32'(rs[i].err), 32'(ops[i].err));
                check_eq($sformatf("%s_rdata%0d", tag, i), rs[i].data, ops[i].exp);
                check_eq($sformatf("%s_lat%0d", tag, i), 32'(rs[i].cyc - ac[i]), 32'(lat));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        #2 reset = 1'b0;
        req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_addr_ok_a", 32'(a_addr_ok), 32'd0);
        check_eq("rst_data_ok_a", 32'(a_data_ok), 32'd0);
        check_eq("rst_rdata_a", a_rdata, 32'h0);
        check_eq("rst_err_a", 32'(a_err), 32'd0);
        check_eq("rst_addr_ok_b", 32'(b_addr_ok), 32'd0);
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_addr_ok_a", 32'(a_addr_ok), 32'd1);
        check_eq("rel_addr_ok_b", 32'(b_addr_ok), 32'd1);
        @(posedge clk); #1;

        // Word store then load of the same word on the next cycle.
        clear_q(); ops.delete();
        add_op(1, 2, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        add_op(0, 2, 32'h10, 32'h0,        0, 32'hDEADBEEF);
        issue_all(0); drain(6);
        check_rsps("st_ld", 0, 2);

        // Back-pressure on the LAT=3 instance.
        ops.delete();
        add_op(1, 2, 32'h50, 32'h50505050, 0, 32'h0);
        add_op(1, 2, 32'h54, 32'h54545454, 0, 32'h0);
        add_op(1, 2, 32'h58, 32'h58585858, 0, 32'h0);
        add_op(1, 2, 32'h5C, 32'h5C5C5C5C, 0, 32'h0);
        issue_all(1); drain(8);
        clear_q(); ops.delete();
        add_op(0, 2, 32'h50, 32'h0, 0, 32'h50505050);
        add_op(0, 2, 32'h54, 32'h0, 0, 32'h54545454);
        add_op(0, 2, 32'h58, 32'h0, 0, 32'h58585858);
        add_op(0, 2, 32'h5C, 32'h0, 0, 32'h5C5C5C5C);
        issue_all(1); drain(10);
        check_rsps("bp", 1, 3);
        if (b_acc.size() == 4) begin
            check_eq("bp_acc1", 32'(b_acc[1] - b_acc[0]), 32'd1);
            check_eq("bp_acc2", 32'(b_acc[2] - b_acc[0]), 32'd3);
            check_eq("bp_acc3", 32'(b_acc[3] - b_acc[0]), 32'd4);
        end

        // Reset while two loads are in flight on the LAT=3 instance.
        clear_q();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h50;
        @(posedge clk); #1;
        addr = 32'h54;
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b0;
        check_eq("mid_nacc", 32'(b_acc.size()), 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_addr_ok_a", 32'(a_addr_ok), 32'd1);
        check_eq("mid_addr_ok_b", 32'(b_addr_ok), 32'd1);
        drain(10);
        check_eq("mid_rsp_b", 32'(b_rsp.size()), 32'd0);
        check_eq("mid_rsp_a", 32'(a_rsp.size()), 32'd0);

        // Byte and half merges plus address aliasing.
        clear_q(); ops.delete();
        add_op(1, 2, 32'h20,        32'h11223344, 0, 32'h0);
        add_op(1, 0, 32'h21,        32'h0000AA00, 0, 32'h0);
        add_op(0, 2, 32'h20,        32'h0,        0, 32'h1122AA44);
        add_op(1, 1, 32'h22,        32'h55660000, 0, 32'h0);
        add_op(0, 2, 32'h20,        32'h0,        0, 32'h5566AA44);
        add_op(1, 0, 32'h23,        32'h77000000, 0, 32'h0);
        add_op(0, 2, 32'h1000_0020, 32'h0,        0, 32'h7766AA44);
        issue_all(0); drain(6);
        check_rsps("merge", 0, 2);

        // Illegal accesses write nothing and answer err=1, rdata=0.
        clear_q(); ops.delete();
        add_op(1, 2, 32'h30, 32'hCAFEF00D, 0, 32'h0);
        add_op(1, 1, 32'h31, 32'hFFFFFFFF, 1, 32'h0);
        add_op(1, 3, 32'h30, 32'hFFFFFFFF, 1, 32'h0);
        add_op(0, 2, 32'h32, 32'h0,        1, 32'h0);
        add_op(0, 1, 32'h33, 32'h0,        1, 32'h0);
        add_op(0, 2, 32'h30, 32'h0,        0, 32'hCAFEF00D);
        issue_all(0); drain(6);
        check_rsps("illegal", 0, 2);

        // Eight back-to-back loads at LAT=2, OQ_DEPTH=2.
        clear_q(); ops.delete();
        add_op(0, 2, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        add_op(0, 2, 32'h20, 32'h0, 0, 32'h7766AA44);
        add_op(0, 2, 32'h30, 32'h0, 0, 32'hCAFEF00D);
        add_op(0, 2, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        add_op(0, 2, 32'h20, 32'h0, 0, 32'h7766AA44);
        add_op(0, 2, 32'h30, 32'h0, 0, 32'hCAFEF00D);
        add_op(0, 2, 32'h10, 32'h0, 0, 32'hDEADBEEF);
        add_op(0, 2, 32'h20, 32'h0, 0, 32'h7766AA44);
        issue_all(0); drain(6);
        check_rsps("thru", 0, 2);
        if (a_acc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                check_eq($sformatf("thru_gap%0d", i), 32'(a_acc[i] - a_acc[0]), 32'(i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsram_resp.md
DSRAM_RESP -- requirements
Module: dsram_resp

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width; the storage array holds 2^AW 32-bit words.
REQ-002 SHALL have parameter LAT, default 2, meaning the request-to-response latency in cycles; legal range 1..7.
REQ-003 SHALL have parameter OQ_DEPTH, default 2, meaning the maximum number of outstanding accepted, unanswered requests; legal range 1..4.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  request valid from the memory-stage initiator.
REQ-008 wr  input  1  1 = store, 0 = load.
REQ-009 size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 addr  input  32  byte address; word index is addr[AW+1:2], and higher bits are ignored (aliasing).
REQ-011 wdata  input  32  store data, lane-aligned: the byte for address A sits on lane A[1:0].
REQ-012 addr_ok  output  1  request accepted this cycle when req && addr_ok.
REQ-013 data_ok  output  1  one-cycle response strobe, one per accepted request.
REQ-014 rdata  output  32  full addressed word, valid when data_ok=1 and err=0; otherwise 0.
REQ-015 err  output  1  misaligned or illegal access, valid with data_ok.

Function
REQ-016 addr_ok SHALL be 1 iff the registered outstanding count < OQ_DEPTH and reset is deasserted; it SHALL NOT depend combinationally on req or on a same-cycle retirement.
REQ-017 An accepted request in cycle c SHALL produce data_ok=1 in exactly cycle c+LAT; responses SHALL return strictly in acceptance order.
REQ-018 Write strobes SHALL be: byte -> 1 lane at addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all 4 lanes.
REQ-019 Illegal accesses are: size=3; half with addr[0]=1; word with addr[1:0]!=0. Such an access SHALL write nothing and SHALL respond with err=1, rdata=0.
REQ-020 A legal store SHALL update the array at the accepting clock edge; its response SHALL carry err=0 and rdata=0.
REQ-021 A legal load SHALL capture the array word at the accepting edge, before that edge's store if any, and return it with its response; a load accepted after a store to the same word SHALL see the stored data.
REQ-022 Outstanding responses SHALL be held in an OQ_DEPTH-entry FIFO. Each entry holds {err, rdata} plus a countdown loaded with LAT-1 at acceptance. The head entry SHALL retire when its countdown is 0.
REQ-023 Acceptance and retirement in the same cycle SHALL leave the count unchanged. FIFO pointers SHALL wrap modulo OQ_DEPTH.
REQ-024 When the FIFO is full, addr_ok=0. A held req SHALL be accepted in the first cycle after a retirement lowers the count.
REQ-025 data_ok has no back-pressure; the initiator SHALL always consume it.
REQ-026 When data_ok=0, rdata=0 and err=0.
REQ-027 With OQ_DEPTH >= LAT, back-to-back requests SHALL be accepted every cycle (full throughput).

Reset
REQ-028 While reset=0: addr_ok=0, data_ok=0, rdata=0, err=0, count=0, FIFO pointers and countdowns=0.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding responses; no data_ok SHALL appear for them after reset release.
REQ-030 The storage array SHALL NOT be cleared by reset; its contents are undefined until written.
REQ-031 addr_ok SHALL rise in the first cycle after reset deasserts.

Verification
REQ-032 Word store then load: store 0xDEADBEEF to addr 0x10, then load 0x10 in the next cycle -> second data_ok at c+1+LAT with rdata=0xDEADBEEF, err=0.
REQ-033 Byte merge: word store 0x11223344 to 0x20, byte store wdata=0x0000AA00 to 0x21, word load 0x20 -> rdata=0x1122AA44.
REQ-034 Misaligned: half store to 0x31, then word load 0x30 -> first response err=1, rdata=0; the array word is unchanged.
REQ-035 Back-pressure: with LAT=3, OQ_DEPTH=2, hold req high for 4 loads -> addr_ok low after 2 acceptances; 4 data_ok pulses in order, each exactly LAT cycles after its acceptance.
REQ-036 Reset mid-flight: accept 2 loads, assert reset for 1 cycle before any data_ok -> no data_ok ever appears for them; addr_ok=1 the cycle after release.
REQ-037 Throughput: with LAT=2, OQ_DEPTH=2, 8 consecutive word loads -> 8 consecutive acceptances and 8 consecutive data_ok cycles with no gaps.
